// File: rtl/bcd_serial_alu.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Responds to a start/done handshake; optional saturation on overflow/underflow.
module bcd_serial_alu #(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   start,
  input  logic                   sub,
  input  logic [DIGITS-1:0][3:0] digits,
  input  logic [DIGITS-1:0][3:0] sum,
  output logic [DIGITS-1:0][3:0] result,
  output logic                   done,
  output logic                   busy,
  output logic                   carry_out
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0][3:0] ALL_NINES = {DIGITS{4'd9}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_r, state_s;
  logic [DIGITS-1:0][3:0]   a_r, b_r, result_r;
  logic                     sub_r, carry_r, carry_out_r, done_r, busy_r;
  logic [IW-1:0]            idx_r;
  logic                     accept_s, last_s;
  logic [3:0]               b_dig_s, dig_s;
  logic [4:0]               sum_s;
  logic                     c_s;

  function automatic logic [DIGITS-1:0][3:0] clamp_bcd(input logic [DIGITS-1:0][3:0] v);
    logic [DIGITS-1:0][3:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      r[i] = (v[i] > 4'd9) ? 4'd9 : v[i];
    end
    return r;
  endfunction

  assign accept_s = start && (state_r != RUN);
  assign last_s   = (idx_r == LAST_IDX);

  // Next-state logic for the handshake FSM
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: if (start) state_s = RUN; else state_s = IDLE;
      RUN:  if (last_s) state_s = DONE; else state_s = RUN;
      DONE: if (start) state_s = RUN; else state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // One BCD digit step; subtract uses the nines' complement of B plus initial carry
  always_comb begin
    b_dig_s = sub_r ? (4'd9 - b_r[idx_r]) : b_r[idx_r];
    sum_s   = {1'b0, a_r[idx_r]} + {1'b0, b_dig_s} + {4'd0, carry_r};
    if (sum_s > 5'd9) begin
      dig_s = 4'(sum_s - 5'd10);
      c_s   = 1'b1;
    end else begin
      dig_s = sum_s[3:0];
      c_s   = 1'b0;
    end
  end

  // State, operand latch and digit-serial datapath
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_r     <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      sub_r       <= 1'b0;
      carry_r     <= 1'b0;
      idx_r       <= '0;
      result_r    <= '0;
      carry_out_r <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r <= state_s;
      done_r  <= (state_s == DONE);
      busy_r  <= (state_s == RUN);
      if (accept_s) begin
        a_r     <= clamp_bcd(digits);
        b_r     <= clamp_bcd(sum);
        sub_r   <= sub;
        carry_r <= sub;
        idx_r   <= '0;
      end else if (state_r == RUN) begin
        carry_r <= c_s;
        idx_r   <= idx_r + 1'b1;
        if (last_s) begin
          carry_out_r <= c_s;
          if (SATURATE && !sub_r && c_s) begin
            result_r <= ALL_NINES;
          end else if (SATURATE && sub_r && !c_s) begin
            result_r <= '0;
          end else begin
            result_r[idx_r] <= dig_s;
          end
        end else begin
          result_r[idx_r] <= dig_s;
        end
      end else begin
        carry_r <= carry_r;
      end
    end
  end

  assign result    = result_r;
  assign done      = done_r;
  assign busy      = busy_r;
  assign carry_out = carry_out_r;

endmodule

// File: tb/tb_bcd_serial_alu.sv
// Self-checking bench for bcd_serial_alu: wrapping and saturating instances side by side,
// scoreboard of expected results built from a decimal model.
module tb_bcd_serial_alu;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic [15:0] sum = 16'h0000;
  logic [15:0] result0, result1;
  logic        done0, done1, busy0, busy1, cout0, cout1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [15:0] r0;
    logic        c0;
    logic [15:0] r1;
    logic        c1;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  bcd_serial_alu #(.DIGITS(4), .SATURATE(1'b0)) dut0 (
    .clk(clk), .resetN(resetN), .start(start), .sub(sub), .digits(digits), .sum(sum),
    .result(result0), .done(done0), .busy(busy0), .carry_out(cout0)
  );

  bcd_serial_alu #(.DIGITS(4), .SATURATE(1'b1)) dut1 (
    .clk(clk), .resetN(resetN), .start(start), .sub(sub), .digits(digits), .sum(sum),
    .result(result1), .done(done1), .busy(busy1), .carry_out(cout1)
  );

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    int d;
    for (int i = 3; i >= 0; i--) begin
      d = int'(v[i*4 +: 4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = 16'h0000;
    int t = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
    exp_t e;
    int ai = bcd2int(a);
    int bi = bcd2int(b);
    int t;
    if (!s) begin
      t = ai + bi;
      e.c0 = (t >= 10000);
      e.r0 = int2bcd(t % 10000);
      e.r1 = e.c0 ? 16'h9999 : e.r0;
    end else begin
      t = ai - bi;
      e.c0 = (t >= 0);
      e.r0 = e.c0 ? int2bcd(t) : int2bcd(t + 10000);
      e.r1 = e.c0 ? e.r0 : 16'h0000;
    end
    e.c1 = e.c0;
    return e;
  endfunction

  // Caller is at a negedge; returns at the negedge where done is high (or on timeout).
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input int pulse_at, output int lat);
    exp_t e;
    start = 1'b1; digits = a; sum = b; sub = s;
    sb.push_back(model(a, b, s));
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done0 && lat < 20) begin
      total++;
      if ((done0 && busy0) || (done1 && busy1) || busy0 !== 1'b1) begin
        bad++;
        $display("FAIL busy_phase lat=%0d busy=%b done=%b required busy=1 done=0", lat, busy0, done0);
      end
      @(negedge clk);
      lat++;
      if (lat == pulse_at) begin
        start = 1'b1; digits = 16'h9999; sum = 16'h9999; sub = 1'b0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    total++;
    if (lat >= 20 || sb.size() == 0) begin
      bad++;
      $display("FAIL done_timeout lat=%0d queued=%0d", lat, sb.size());
    end else begin
      e = sb.pop_front();
      if (result0 !== e.r0 || cout0 !== e.c0 || done1 !== 1'b1 || busy0 !== 1'b0 ||
          result1 !== e.r1 || cout1 !== e.c1) begin
        bad++;
        $display("FAIL result got %h/%b sat %h/%b done1=%b required %h/%b sat %h/%b",
                 result0, cout0, result1, cout1, done1, e.r0, e.c0, e.r1, e.c1);
      end
      total++;
      if (lat != 4) begin
        bad++;
        $display("FAIL latency got %0d required 4", lat);
      end
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (result0 !== 16'h0 || result1 !== 16'h0 || done0 !== 1'b0 || busy0 !== 1'b0 ||
        cout0 !== 1'b0 || done1 !== 1'b0 || busy1 !== 1'b0 || cout1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got r=%h d=%b b=%b c=%b required all zero", result0, done0, busy0, cout0);
    end
    resetN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    int lat;
    do_op(16'h1234, 16'h5678, 1'b0, -1, lat);
    repeat (10) @(negedge clk);
    total++;
    if (result0 !== 16'h6912 || cout0 !== 1'b0 || done0 !== 1'b0 || busy0 !== 1'b0) begin
      bad++;
      $display("FAIL add_hold got %h/%b done=%b required 6912/0 done=0", result0, cout0, done0);
    end
    do_op(16'h9999, 16'h0001, 1'b0, -1, lat);
    @(negedge clk);
    do_op(16'h00F3, 16'h0001, 1'b0, -1, lat);
    @(negedge clk);
  endtask

  task automatic test_sub();
    int lat;
    do_op(16'h0100, 16'h0001, 1'b1, -1, lat);
    @(negedge clk);
    do_op(16'h0000, 16'h0001, 1'b1, -1, lat);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      do_op(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), -1, lat);
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    do_op(16'h0042, 16'h0017, 1'b0, 2, lat);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (done0 !== 1'b0 || busy0 !== 1'b0) begin
        bad++;
        $display("FAIL ignored_start cycle=%0d done=%b busy=%b required 0/0", i, done0, busy0);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_op(16'h1111, 16'h2222, 1'b0, -1, lat);
    do_op(16'h0005, 16'h0005, 1'b0, -1, lat);
    total++;
    if (result0 !== 16'h0010) begin
      bad++;
      $display("FAIL b2b_result got %h required 0010", result0);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    start = 1'b1; digits = 16'h1234; sum = 16'h1111; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    total++;
    if (result0 !== 16'h0 || done0 !== 1'b0 || busy0 !== 1'b0 || cout0 !== 1'b0 ||
        result1 !== 16'h0 || busy1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid got r=%h d=%b b=%b c=%b required all zero", result0, done0, busy0, cout0);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (done0 !== 1'b0 || done1 !== 1'b0 || busy0 !== 1'b0) begin
        bad++;
        $display("FAIL reset_discard cycle=%0d done=%b busy=%b required 0/0", i, done0, busy0);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_op();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got %0d required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
